ahb_interconnect: RTL and testbench



---
 rtl/ahb_pkg.sv | 16 +
 rtl/ahb_default_slave.sv | 74 +++++++
 rtl/ahb_interconnect.sv | 97 +++++++++
 tb/tb_ahb_interconnect.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and default-slave state type for the interconnect.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;
endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response plus error log.
// state   | meaning
// DS_IDLE | no error in progress, zero-wait OKAY
// DS_ERR1 | first ERROR cycle, hready low
// DS_ERR2 | second ERROR cycle, hready high, may chain into a new ERR1
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 sel_default,
    input  logic [1:0]           htrans,
    input  logic                 hready,
    input  logic [ADDR_W-1:0]    haddr,
    input  logic                 err_clr,
    output logic                 ds_hready,
    output logic                 ds_hresp,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    err_addr
);
    ds_state_t state;
    logic      err_take;
    logic      log_err;

    assign err_take = sel_default && hready &&
                      (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign log_err  = err_take && (state != DS_ERR1);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= HRESP_OKAY;
            err_cnt   <= '0;
            err_addr  <= '0;
        end else begin
            case (state)
                DS_IDLE, DS_ERR2: begin
                    if (err_take) begin
                        state     <= DS_ERR1;
                        ds_hready <= 1'b0;
                        ds_hresp  <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        ds_hready <= 1'b1;
                        ds_hresp  <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_ERROR;
                end
                default: begin
                    state     <= DS_IDLE;
                    ds_hready <= 1'b1;
                    ds_hresp  <= HRESP_OKAY;
                end
            endcase

            // clear wins over a same-cycle increment
            if (err_clr)
                err_cnt <= '0;
            else if (log_err && err_cnt != '1)
                err_cnt <= err_cnt + ERR_CNT_W'(1);

            if (log_err)
                err_addr <= haddr;
        end
    end
endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB interconnect: base/mask address decode, registered
// data-phase select, response mux and built-in default slave.
module ahb_interconnect
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
    parameter int ERR_CNT_W  = 8
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [NUM_SLAVES-1:0]        hsel,
    output logic                         hready,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hresp,
    input  logic                         err_clr,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic [ADDR_W-1:0]            err_addr
);
    localparam int SEL_W = $clog2(NUM_SLAVES + 1);
    localparam logic [SEL_W-1:0] DSEL_DEFAULT = SEL_W'(NUM_SLAVES);

    logic [NUM_SLAVES-1:0] match;
    logic [NUM_SLAVES-1:0] dhit;
    logic [SEL_W-1:0]      sel_idx;
    logic [SEL_W-1:0]      dsel;
    logic                  sel_default;
    logic                  ds_hready;
    logic                  ds_hresp;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
        assign match[gi] = (haddr & SLV_MASK[gi*ADDR_W +: ADDR_W]) ==
                           (SLV_BASE[gi*ADDR_W +: ADDR_W] & SLV_MASK[gi*ADDR_W +: ADDR_W]);
        assign dhit[gi]  = (dsel == SEL_W'(gi));
    end

    // descending scan so the lowest matching index overrides on overlap
    always_comb begin
        hsel    = '0;
        sel_idx = DSEL_DEFAULT;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hsel    = '0;
                hsel[i] = 1'b1;
                sel_idx = SEL_W'(i);
            end
        end
    end

    assign sel_default = (sel_idx == DSEL_DEFAULT);

    always_ff @(posedge hclk) begin
        if (hreset)
            dsel <= DSEL_DEFAULT;
        else if (hready)
            dsel <= sel_idx;
    end

    always_comb begin
        hrdata = '0;
        hready = ds_hready;
        hresp  = ds_hresp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dhit[i]) begin
                hrdata = hrdata_s[i*DATA_W +: DATA_W];
                hready = hreadyout_s[i];
                hresp  = hresp_s[i];
            end
        end
    end

    ahb_default_slave #(
        .ADDR_W    (ADDR_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_default_slave (
        .hclk        (hclk),
        .hreset      (hreset),
        .sel_default (sel_default),
        .htrans      (htrans),
        .hready      (hready),
        .haddr       (haddr),
        .err_clr     (err_clr),
        .ds_hready   (ds_hready),
        .ds_hresp    (ds_hresp),
        .err_cnt     (err_cnt),
        .err_addr    (err_addr)
    );
endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect with a read-data scoreboard queue.
module tb_ahb_interconnect;
    localparam logic [31:0] DAT0 = 32'hD000_0000;
    localparam logic [31:0] DAT1 = 32'hD111_1111;
    localparam logic [31:0] DAT2 = 32'hD222_2222;
    localparam logic [31:0] DAT3 = 32'hD333_3333;

    logic         hclk = 1'b0;
    logic         hreset;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [3:0]   hsel;
    logic         hready;
    logic [127:0] hrdata_s;
    logic [3:0]   hreadyout_s;
    logic [3:0]   hresp_s;
    logic [31:0]  hrdata;
    logic         hresp;
    logic         err_clr;
    logic [1:0]   err_cnt;
    logic [31:0]  err_addr;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 hclk = ~hclk;

    ahb_interconnect #(.ERR_CNT_W(2)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .haddr       (haddr),
        .htrans      (htrans),
        .hsel        (hsel),
        .hready      (hready),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .err_clr     (err_clr),
        .err_cnt     (err_cnt),
        .err_addr    (err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return DAT0;
            4'h1:    return DAT1;
            4'h2:    return DAT2;
            4'h3:    return DAT3;
            default: return 32'h0;
        endcase
    endfunction

    // one bus cycle: drive, check address-phase and response outputs, run scoreboard
    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] rdy,
                        input logic [3:0] rsp, input logic clr, input logic [3:0] e_hsel,
                        input logic e_rdy, input logic e_resp);
        @(posedge hclk);
        #2;
        haddr       = a;
        htrans      = t;
        hreadyout_s = rdy;
        hresp_s     = rsp;
        err_clr     = clr;
        #1;
        chk("hsel", 64'(hsel), 64'(e_hsel));
        chk("hready", 64'(hready), 64'(e_rdy));
        chk("hresp", 64'(hresp), 64'(e_resp));
        if (hready && exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("hrdata", 64'(hrdata), 64'(e));
        end
        if (hready && t[1])
            exp_q.push_back(exp_data(a));
    endtask

    task automatic unm(input logic [31:0] a, input logic clr);
        step(a, 2'b10, 4'hF, 4'h0, clr, 4'b0000, 1'b1, 1'b0);
        step(32'h0, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b1);
        step(32'h0, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1);
    endtask

    initial begin
        hrdata_s    = {DAT3, DAT2, DAT1, DAT0};
        hreset      = 1'b1;
        haddr       = 32'h0;
        htrans      = 2'b00;
        hreadyout_s = 4'hF;
        hresp_s     = 4'h0;
        err_clr     = 1'b0;
        repeat (3) @(posedge hclk);
        #2 hreset = 1'b0;
        #1;
        chk("rst_hready", 64'(hready), 64'd1);
        chk("rst_hresp", 64'(hresp), 64'd0);
        chk("rst_hrdata", 64'(hrdata), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);

        // zero-wait mapped transfers
        step(32'h1000_0010, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 1'b0);
        step(32'h3000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b1000, 1'b1, 1'b0);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0);

        // slave2 stalls three cycles while slave0 address waits
        step(32'h2000_0004, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(32'h0000_0000, 2'b10, 4'b1011, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b0);
            chk("stall_hrdata", 64'(hrdata), 64'(DAT2));
        end
        step(32'h0000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0);

        // single unmapped NONSEQ
        unm(32'h5000_0000, 1'b0);
        chk("err_cnt_1", 64'(err_cnt), 64'd1);
        chk("err_addr_1", 64'(err_addr), 64'h5000_0000);

        // unmapped BUSY is a zero-wait OKAY
        step(32'h8000_0000, 2'b01, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 1'b0);
        chk("busy_err_addr", 64'(err_addr), 64'h5000_0000);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0);
        chk("clr_err_cnt", 64'(err_cnt), 64'd0);
        chk("clr_err_addr", 64'(err_addr), 64'h5000_0000);

        // back-to-back unmapped, second accepted in ERR2
        step(32'h6000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
        step(32'h7000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1);
        step(32'h7000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b1);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b1);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1);
        chk("err_cnt_2", 64'(err_cnt), 64'd2);
        chk("err_addr_2", 64'(err_addr), 64'h7000_0000);

        // slave two-cycle ERROR passes through untouched
        step(32'h1000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 1'b0);
        step(32'h0000_0000, 2'b00, 4'b1101, 4'b0010, 1'b0, 4'b0001, 1'b0, 1'b1);
        step(32'h0000_0000, 2'b00, 4'hF, 4'b0010, 1'b0, 4'b0001, 1'b1, 1'b1);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 1'b0);
        chk("slv_err_cnt", 64'(err_cnt), 64'd2);

        // saturation at 3, then clear coincident with an error
        for (int i = 0; i < 5; i++) begin
            unm(32'hA000_0000 + 32'(i), 1'b0);
            chk("sat_err_cnt", 64'(err_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
        end
        chk("sat_err_addr", 64'(err_addr), 64'hA000_0004);
        unm(32'hB000_0000, 1'b1);
        chk("clr_sat_cnt", 64'(err_cnt), 64'd0);
        unm(32'hC000_0000, 1'b1);
        chk("clr_prio_cnt", 64'(err_cnt), 64'd0);
        unm(32'hD000_0000, 1'b0);
        chk("after_clr_cnt", 64'(err_cnt), 64'd1);

        // reset during ERR1
        step(32'h9000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0);
        @(posedge hclk);
        #2;
        haddr  = 32'h0;
        htrans = 2'b00;
        hreset = 1'b1;
        #1;
        chk("err1_hready", 64'(hready), 64'd0);
        chk("err1_hresp", 64'(hresp), 64'd1);
        @(posedge hclk);
        #2 hreset = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_hready", 64'(hready), 64'd1);
        chk("mid_rst_hresp", 64'(hresp), 64'd0);
        chk("mid_rst_hrdata", 64'(hrdata), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("mid_rst_err_addr", 64'(err_addr), 64'd0);

        step(32'h3000_0000, 2'b10, 4'hF, 4'h0, 1'b0, 4'b1000, 1'b1, 1'b0);
        step(32'h0000_0000, 2'b00, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
